lif_array: RTL and testbench

LIF_ARRAY -- requirements
Module: lif_array

---
 rtl/lif_pkg.sv | 36 +++
 rtl/lif_update.sv | 74 +++++++
 rtl/lif_array.sv | 184 ++++++++++++++++++
 tb/tb_lif_array.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the leaky integrate-and-fire neuron array:
// the sequencer state encoding, the refractory-exit mode selectors, the
// width of the per-neuron refractory step counter and a signed saturation
// helper used by the neuron update datapath.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Refractory exit: on membrane undershoot, or after a fixed number of steps.
  localparam int REFR_MODE_THRESH = 0;
  localparam int REFR_MODE_TIMED  = 1;

  // Width of the per-neuron refractory step counter.
  localparam int RC_W = 8;

  // Clamp a sign-extended value into the range of a w-bit signed number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                    input int                 w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) begin
      sat_signed = hi;
    end else if (x < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = x;
    end
  endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron update, shared by all neurons of the array.
// Ports:
//   v_i / i_i       current membrane and input (signed, W bits)
//   refr_i / rcnt_i current refractory flag and refractory step counter
//   v_o / spike_o   next membrane and spike flag
//   refr_o / rcnt_o next refractory flag and refractory step counter
module lif_update
  import lif_pkg::*;
#(
  parameter int                  W           = 8,
  parameter int                  LSH         = 3,
  parameter logic signed [W-1:0] THRESH      = W'(64),
  parameter logic signed [W-1:0] V_MAX       = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] NEG_DRIVE   = W'(16),
  parameter int                  REFR_MODE   = REFR_MODE_THRESH,
  parameter int                  REFR_CYCLES = 3
) (
  input  logic signed [W-1:0]    v_i,
  input  logic signed [W-1:0]    i_i,
  input  logic                   refr_i,
  input  logic        [RC_W-1:0] rcnt_i,
  output logic signed [W-1:0]    v_o,
  output logic                   spike_o,
  output logic                   refr_o,
  output logic        [RC_W-1:0] rcnt_o
);

  // Two guard bits so V + I - leak (and V - leak - drive) can never wrap.
  localparam int XW = W + 2;

  logic signed [XW-1:0] v_x, i_x, leak_x, thr_x, nd_x, norm_x, refr_x;
  logic signed [W-1:0]  v_norm_s, v_refr_s;
  logic        [RC_W-1:0] rcnt_dec_s;

  assign v_x      = XW'(v_i);
  assign i_x      = XW'(i_i);
  assign thr_x    = XW'(THRESH);
  assign nd_x     = XW'(NEG_DRIVE);
  assign leak_x   = v_x >>> LSH;
  assign norm_x   = v_x + i_x - leak_x;
  assign refr_x   = v_x - leak_x - nd_x;
  assign v_norm_s = W'(sat_signed(32'(norm_x), W));
  assign v_refr_s = W'(sat_signed(32'(refr_x), W));
  assign rcnt_dec_s = (rcnt_i != '0) ? (rcnt_i - RC_W'(1)) : '0;

  // Select the integrate/fire path or the refractory path.
  always_comb begin
    v_o     = v_norm_s;
    spike_o = 1'b0;
    refr_o  = refr_i;
    rcnt_o  = rcnt_i;
    if (refr_i) begin
      // Input is ignored while refractory; the membrane is driven downward.
      v_o = v_refr_s;
      if (REFR_MODE == REFR_MODE_TIMED) begin
        rcnt_o = rcnt_dec_s;
        refr_o = (rcnt_dec_s != '0);
      end else begin
        rcnt_o = rcnt_i;
        refr_o = (XW'(v_refr_s) > -thr_x);
      end
    end else if (v_norm_s >= THRESH) begin
      v_o     = V_MAX;
      spike_o = 1'b1;
      refr_o  = 1'b1;
      rcnt_o  = RC_W'(REFR_CYCLES);
    end else begin
      v_o     = v_norm_s;
      refr_o  = 1'b0;
      rcnt_o  = rcnt_i;
    end
  end

endmodule

// File: rtl/lif_array.sv
// Array of N_NEUR leaky integrate-and-fire neurons time-multiplexed over one
// shared update datapath. A timestep walks the neurons one per clock.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   step_valid/step_ready timestep request handshake (ready only when idle)
//   I_vec                 packed signed inputs, neuron k at [k*W +: W]
//   done                  one-cycle pulse when a timestep completes
//   spike_vec / refr_vec  spikes of the last timestep, refractory flags
//   rd_sel/rd_v/rd_cnt    membrane and spike-count readback of one neuron
//   cnt_clr               synchronous clear of all spike counters
module lif_array
  import lif_pkg::*;
#(
  parameter int                  N_NEUR      = 4,
  parameter int                  W           = 8,
  parameter int                  LSH         = 3,
  parameter logic signed [W-1:0] THRESH      = W'(64),
  parameter logic signed [W-1:0] V_MAX       = {1'b0, {(W-1){1'b1}}},
  parameter logic signed [W-1:0] NEG_DRIVE   = W'(16),
  parameter int                  REFR_MODE   = REFR_MODE_THRESH,
  parameter int                  REFR_CYCLES = 3
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        step_valid,
  output logic                                        step_ready,
  input  logic [N_NEUR*W-1:0]                         I_vec,
  output logic                                        done,
  output logic [N_NEUR-1:0]                           spike_vec,
  output logic [N_NEUR-1:0]                           refr_vec,
  input  logic [$clog2(N_NEUR > 1 ? N_NEUR : 2)-1:0]  rd_sel,
  output logic signed [W-1:0]                         rd_v,
  input  logic                                        cnt_clr,
  output logic [7:0]                                  rd_cnt
);

  localparam int SEL_W = $clog2(N_NEUR > 1 ? N_NEUR : 2);

  state_e                state_q;
  logic [SEL_W-1:0]      idx_q;
  logic [N_NEUR*W-1:0]   in_q;
  logic signed [W-1:0]   v_q [N_NEUR];
  logic [N_NEUR-1:0]     refr_q;
  logic [RC_W-1:0]       rcnt_q [N_NEUR];
  logic [7:0]            cnt_q [N_NEUR];
  logic [N_NEUR-1:0]     spike_acc_q, spike_acc_d, spike_vec_q;
  logic                  done_q, ready_q;

  logic signed [W-1:0]   cur_v_s, cur_i_s, upd_v_d;
  logic                  upd_spike_d, upd_refr_d, last_s;
  logic [RC_W-1:0]       upd_rcnt_d;

  assign cur_v_s = v_q[idx_q];
  assign cur_i_s = in_q[32'(idx_q)*W +: W];
  assign last_s  = (idx_q == SEL_W'(N_NEUR - 1));

  lif_update #(
    .W          (W),
    .LSH        (LSH),
    .THRESH     (THRESH),
    .V_MAX      (V_MAX),
    .NEG_DRIVE  (NEG_DRIVE),
    .REFR_MODE  (REFR_MODE),
    .REFR_CYCLES(REFR_CYCLES)
  ) u_update (
    .v_i    (cur_v_s),
    .i_i    (cur_i_s),
    .refr_i (refr_q[idx_q]),
    .rcnt_i (rcnt_q[idx_q]),
    .v_o    (upd_v_d),
    .spike_o(upd_spike_d),
    .refr_o (upd_refr_d),
    .rcnt_o (upd_rcnt_d)
  );

  // Spikes of the timestep in flight, including the neuron being updated now.
  always_comb begin
    spike_acc_d        = spike_acc_q;
    spike_acc_d[idx_q] = upd_spike_d;
  end

  // Timestep sequencer; spike_vec is only published on entry to DONE so an
  // aborted timestep never exposes partial results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      in_q        <= '0;
      spike_acc_q <= '0;
      spike_vec_q <= '0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (step_valid && ready_q) begin
            in_q        <= I_vec;
            idx_q       <= '0;
            spike_acc_q <= '0;
            ready_q     <= 1'b0;
            state_q     <= ST_RUN;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          spike_acc_q <= spike_acc_d;
          if (last_s) begin
            idx_q       <= '0;
            spike_vec_q <= spike_acc_d;
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            idx_q <= idx_q + SEL_W'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          idx_q   <= '0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Neuron state: written back one neuron per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEUR; k++) begin
        v_q[k]    <= '0;
        rcnt_q[k] <= '0;
      end
      refr_q <= '0;
    end else if (state_q == ST_RUN) begin
      v_q[idx_q]    <= upd_v_d;
      refr_q[idx_q] <= upd_refr_d;
      rcnt_q[idx_q] <= upd_rcnt_d;
    end
  end

  // Saturating spike counters; a clear wins over an increment on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_NEUR; k++) begin
        cnt_q[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < N_NEUR; k++) begin
        if (cnt_clr) begin
          cnt_q[k] <= 8'd0;
        end else if ((state_q == ST_RUN) && (idx_q == SEL_W'(k)) &&
                     upd_spike_d && (cnt_q[k] != 8'hFF)) begin
          cnt_q[k] <= cnt_q[k] + 8'd1;
        end
      end
    end
  end

  // Readback mux; selects beyond the array read as zero.
  always_comb begin
    rd_v   = '0;
    rd_cnt = 8'd0;
    if (32'(rd_sel) < N_NEUR) begin
      rd_v   = v_q[rd_sel];
      rd_cnt = cnt_q[rd_sel];
    end else begin
      rd_v   = '0;
      rd_cnt = 8'd0;
    end
  end

  assign step_ready = ready_q;
  assign done       = done_q;
  assign spike_vec  = spike_vec_q;
  assign refr_vec   = refr_q;

endmodule

// File: tb/tb_lif_array.sv
module tb_lif_array;

  localparam int N = 4;
  localparam int W = 8;

  logic                clk = 1'b0;
  logic                rst, step_valid, cnt_clr;
  logic [N*W-1:0]      I_vec;
  logic [1:0]          rd_sel;

  logic                ready0, done0, ready1, done1;
  logic [N-1:0]        spike0, refr0, spike1, refr1;
  logic signed [W-1:0] rdv0, rdv1;
  logic [7:0]          rdcnt0, rdcnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Default configuration: refractory exit on undershoot.
  lif_array #(.N_NEUR(N), .W(W)) dut0 (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(ready0),
    .I_vec(I_vec), .done(done0), .spike_vec(spike0), .refr_vec(refr0),
    .rd_sel(rd_sel), .rd_v(rdv0), .cnt_clr(cnt_clr), .rd_cnt(rdcnt0)
  );

  // Timed refractory configuration, 3 steps.
  lif_array #(.N_NEUR(N), .W(W), .REFR_MODE(1), .REFR_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .step_valid(step_valid), .step_ready(ready1),
    .I_vec(I_vec), .done(done1), .spike_vec(spike1), .refr_vec(refr1),
    .rd_sel(rd_sel), .rd_v(rdv1), .cnt_clr(cnt_clr), .rd_cnt(rdcnt1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_i(input int i0, input int i1, input int i2, input int i3);
    I_vec = {8'(i3), 8'(i2), 8'(i1), 8'(i0)};
  endtask

  // Wait (bounded) for done; lat counts negedges, rl counts negedges with ready low.
  task automatic wait_done(output int lat, output int rl);
    lat = 0;
    rl  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      step_valid = 1'b0;
      if (!ready0) rl++;
      if (done0) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) check_eq("done_timeout", 0, 1);
  endtask

  task automatic run_step(output int lat, output int rl);
    @(negedge clk);
    step_valid = 1'b1;
    @(posedge clk);
    wait_done(lat, rl);
  endtask

  // Expected neuron-0 trajectory with I = 16.
  int exp_v_m0 [17] = '{16, 30, 43, 54, 127, 96, 68, 44, 23, 5, -11, -25, -37, -48, -58, -66, -41};
  int exp_r_m0 [17] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  int exp_v_m1 [9]  = '{16, 30, 43, 54, 127, 96, 68, 44, 55};
  int exp_r_m1 [9]  = '{0, 0, 0, 0, 1, 1, 1, 0, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rl, d_first, d_second, rdy_between, n_done;
    rst = 1'b1; step_valid = 1'b0; cnt_clr = 1'b0; rd_sel = 2'd0; I_vec = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_ready0", ready0, 1);
    check_eq("rst_ready1", ready1, 1);
    check_eq("rst_done0", done0, 0);
    check_eq("rst_spike0", spike0, 0);
    check_eq("rst_refr0", refr0, 0);
    check_eq("rst_v0", rdv0, 0);
    check_eq("rst_cnt0", rdcnt0, 0);

    // Neuron 0: +16, neuron 1: -128 (saturation), neuron 2: 0, neuron 3: 70
    set_i(16, -128, 0, 70);
    for (int s = 1; s <= 17; s++) begin
      run_step(lat, rl);
      if (s == 1) begin
        check_eq("latency", lat, 5);
        check_eq("ready_low_cycles", rl, 5);
        check_eq("done_both", done1, 1);
        check_eq("spike_s1_m0", spike0, 4'b1000);
        check_eq("spike_s1_m1", spike1, 4'b1000);
      end
      rd_sel = 2'd0; #1;
      check_eq($sformatf("m0_v0_s%0d", s), rdv0, exp_v_m0[s-1]);
      check_eq($sformatf("m0_refr0_s%0d", s), refr0[0], exp_r_m0[s-1]);
      if (s <= 9) begin
        check_eq($sformatf("m1_v0_s%0d", s), rdv1, exp_v_m1[s-1]);
        check_eq($sformatf("m1_refr0_s%0d", s), refr1[0], exp_r_m1[s-1]);
      end
      rd_sel = 2'd1; #1;
      check_eq($sformatf("m0_sat_s%0d", s), rdv0, -128);
      check_eq($sformatf("m1_sat_s%0d", s), rdv1, -128);
      if (s == 5) begin
        check_eq("spike_s5_m0", spike0, 4'b0001);
        check_eq("spike_s5_m1", spike1, 4'b1001);
        rd_sel = 2'd0; #1;
        check_eq("cnt_n0_m0", rdcnt0, 1);
        check_eq("cnt_n0_m1", rdcnt1, 1);
        rd_sel = 2'd3; #1;
        check_eq("cnt_n3_m0", rdcnt0, 1);
        check_eq("cnt_n3_m1", rdcnt1, 2);
        check_eq("v_n3_m0", rdv0, 23);
        check_eq("v_n3_m1", rdv1, 127);
      end
      if (s == 1) begin
        @(negedge clk);
        check_eq("done_pulse_width", done0, 0);
      end
    end

    // Back-to-back steps with step_valid held high
    @(negedge clk);
    step_valid = 1'b1;
    d_first = -1; d_second = -1; rdy_between = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done0) begin
        if (d_first < 0) d_first = c;
        else if (d_second < 0) d_second = c;
      end
      if (d_first >= 0 && d_second < 0 && ready0 && !done0) rdy_between++;
    end
    step_valid = 1'b0;
    check_eq("b2b_period", d_second - d_first, 6);
    check_eq("b2b_idle_cycles", rdy_between, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready0) break;
    end

    // Reset in the middle of RUN
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    check_eq("running_before_rst", ready0, 0);
    rst = 1'b1;
    rd_sel = 2'd0; #1;
    check_eq("mid_rst_ready0", ready0, 1);
    check_eq("mid_rst_done0", done0, 0);
    check_eq("mid_rst_spike0", spike0, 0);
    check_eq("mid_rst_spike1", spike1, 0);
    check_eq("mid_rst_refr0", refr0, 0);
    check_eq("mid_rst_v0", rdv0, 0);
    check_eq("mid_rst_cnt1", rdcnt1, 0);
    rd_sel = 2'd3; #1;
    check_eq("mid_rst_cnt3_m1", rdcnt1, 0);
    @(negedge clk);
    rst = 1'b0;
    run_step(lat, rl);
    check_eq("post_rst_latency", lat, 5);
    rd_sel = 2'd0; #1;
    check_eq("post_rst_v0_m0", rdv0, 16);
    check_eq("post_rst_v0_m1", rdv1, 16);
    check_eq("post_rst_spike0", spike0, 4'b1000);

    // Counter clear coinciding with neuron 0's spike edge
    set_i(127, 127, 127, 127);
    @(negedge clk);
    step_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt_clr = 1'b0;
    wait_done(lat, rl);
    rd_sel = 2'd0; #1;
    check_eq("clr_prio_spike", spike0[0], 1);
    check_eq("clr_prio_m0", rdcnt0, 0);
    check_eq("clr_prio_m1", rdcnt1, 0);
    rd_sel = 2'd2; #1;
    check_eq("cnt_after_clr_n2", rdcnt0, 1);

    // Timed refractory: three refractory steps, then a spike
    for (int s = 0; s < 4; s++) run_step(lat, rl);
    rd_sel = 2'd0; #1;
    check_eq("m1_resume_cnt", rdcnt1, 1);
    check_eq("m1_resume_v", rdv1, 127);
    check_eq("m0_still_refr_cnt", rdcnt0, 0);
    check_eq("m0_still_refr_v", rdv0, 23);

    // Spike counter saturation
    @(negedge clk);
    step_valid = 1'b1;
    n_done = 0;
    for (int c = 0; c < 8000 && n_done < 1030; c++) begin
      @(negedge clk);
      if (done0) n_done++;
    end
    step_valid = 1'b0;
    check_eq("sat_steps_done", n_done, 1030);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready0) break;
    end
    rd_sel = 2'd0; #1;
    check_eq("cnt_saturated", rdcnt1, 255);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    check_eq("cnt_clear", rdcnt1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
